// File: rtl/data_mem_pkg.sv
// Shared constants, decode-region enum and status-byte packing for the data-store responder.
package data_mem_pkg;

   localparam logic [7:0] DONE_ADDR   = 8'hFD;
   localparam logic [7:0] STATUS_ADDR = 8'hFE;
   localparam logic [7:0] RESULT_ADDR = 8'hFF;

   typedef enum logic [2:0] {
      REG_RAM,
      REG_DONE,
      REG_STATUS,
      REG_RESULT,
      REG_NONE
   } region_t;

   // Status layout: {overflow, done, count}; count is zero-extended into the low six bits.
   function automatic logic [7:0] pack_status(input logic ovf, input logic dn, input logic [5:0] cnt);
      return {ovf, dn, cnt};
   endfunction

endpackage

// File: rtl/data_mem_responder_result_fifo.sv
// Result FIFO: register storage with combinational head, async active-high reset.
module result_fifo #(
   parameter int DWIDTH     = 8,
   parameter int FIFO_DEPTH = 4,
   localparam int AW        = $clog2(FIFO_DEPTH),
   localparam int CW        = AW + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              pop,
   output logic [DWIDTH-1:0] head,
   output logic              full,
   output logic              empty,
   output logic [CW-1:0]     count,
   output logic              ovf_pulse
);

   logic [DWIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [CW-1:0]     count_reg;
   logic              pop_fire;
   logic              push_fire;

   assign empty     = (count_reg == '0);
   assign full      = (count_reg == CW'(FIFO_DEPTH));
   assign count     = count_reg;
   assign pop_fire  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push while full still lands.
   assign push_fire = push && (!full || pop_fire);
   assign ovf_pulse = push && full && !pop_fire;
   assign head      = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_fire, pop_fire})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_fire) mem[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-store responder: byte RAM plus MMIO window (done, status, result FIFO).
// Optional store-address checking is enabled by defining DATA_MEM_ADDR_CHECK_EN.
module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int          DWIDTH     = 8,
   parameter int          RAM_DEPTH  = 64,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [7:0]  DONE_CODE  = 8'h01
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memwrite,
   input  logic [DWIDTH-1:0] dataadr,
   input  logic [DWIDTH-1:0] writedata,
   output logic [DWIDTH-1:0] readdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_data,
   output logic              done,
   output logic              overflow,
   output logic              addr_err
);

   localparam int RAM_AW  = $clog2(RAM_DEPTH);
   localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

   region_t            region;
   logic [RAM_AW-1:0]  ram_idx;
   logic [DWIDTH-1:0]  ram_reg [RAM_DEPTH];
   logic               ram_we;
   logic               fifo_push;
   logic               fifo_empty;
   logic [FIFO_CW-1:0] fifo_count;
   logic               fifo_ovf;
   logic               done_reg;
   logic               overflow_reg;

   always_comb begin
      region = REG_NONE;
      if (dataadr < DWIDTH'(RAM_DEPTH))  region = REG_RAM;
      else if (dataadr == DONE_ADDR)     region = REG_DONE;
      else if (dataadr == STATUS_ADDR)   region = REG_STATUS;
      else if (dataadr == RESULT_ADDR)   region = REG_RESULT;
   end

   assign ram_idx   = dataadr[RAM_AW-1:0];
   assign ram_we    = memwrite && (region == REG_RAM);
   assign fifo_push = memwrite && (region == REG_RESULT);

   // Per-byte registers so the whole RAM clears on the asynchronous reset.
   for (genvar gi = 0; gi < RAM_DEPTH; gi++) begin : g_ram
      always_ff @(posedge clk or posedge reset) begin
         if (reset)                                 ram_reg[gi] <= '0;
         else if (ram_we && ram_idx == RAM_AW'(gi)) ram_reg[gi] <= writedata;
      end
   end

   result_fifo #(
      .DWIDTH     (DWIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (writedata),
      .pop       (out_ready),
      .head      (out_data),
      .full      (),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .ovf_pulse (fifo_ovf)
   );

   assign out_valid = !fifo_empty;

   always_comb begin
      readdata = '0;
      case (region)
         REG_RAM:    readdata = ram_reg[ram_idx];
         REG_STATUS: readdata = pack_status(overflow_reg, done_reg, 6'(fifo_count));
         REG_RESULT: readdata = out_data;
         default:    readdata = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         if (memwrite && region == REG_DONE && writedata == DONE_CODE) done_reg <= 1'b1;
         if (fifo_ovf) overflow_reg <= 1'b1;
      end
   end

   assign done     = done_reg;
   assign overflow = overflow_reg;

`ifdef DATA_MEM_ADDR_CHECK_EN
   logic addr_err_reg;

   // STATUS is read-only, so a store to it counts as a bad address too.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         addr_err_reg <= 1'b0;
      else if (memwrite && (region == REG_NONE || region == REG_STATUS))
         addr_err_reg <= 1'b1;
   end

   assign addr_err = addr_err_reg;
`else
   assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed plan followed by random loads/stores.
module tb_data_mem_responder;

   localparam int RAM_DEPTH  = 64;
   localparam int FIFO_DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       memwrite = 1'b0;
   logic [7:0] dataadr = 8'h00;
   logic [7:0] writedata = 8'h00;
   logic [7:0] readdata;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       done;
   logic       overflow;
   logic       addr_err;

   int checks = 0;
   int errors = 0;

   logic [7:0] ram_m [RAM_DEPTH];
   logic [7:0] mdl_q [$];
   logic [7:0] exp_q [$];
   logic       done_m, ovf_m, aerr_m;

   always #5 clk = ~clk;

   data_mem_responder dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .dataadr   (dataadr),
      .writedata (writedata),
      .readdata  (readdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .done      (done),
      .overflow  (overflow),
      .addr_err  (addr_err)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_read(input logic [7:0] a);
      if (a < RAM_DEPTH)  return ram_m[a];
      if (a == 8'hFE)     return {ovf_m, done_m, 6'(mdl_q.size())};
      if (a == 8'hFF)     return (mdl_q.size() != 0) ? mdl_q[0] : 8'h00;
      return 8'h00;
   endfunction

   task automatic clear_model();
      foreach (ram_m[i]) ram_m[i] = 8'h00;
      mdl_q.delete();
      exp_q.delete();
      done_m = 1'b0;
      ovf_m  = 1'b0;
      aerr_m = 1'b0;
   endtask

   // One bus cycle: drive, check combinational/sticky outputs at negedge, then advance the model.
   task automatic cycle(input bit we, input logic [7:0] adr, input logic [7:0] wd, input bit rdy);
      bit pop;
      memwrite  = we;
      dataadr   = adr;
      writedata = wd;
      out_ready = rdy;
      @(negedge clk);
      $display("txn t=%0t we=%0d adr=%h wd=%h rdy=%0d rd=%h valid=%0d head=%h", $time, we, adr, wd, rdy,
               readdata, out_valid, out_data);
      check("readdata", readdata, model_read(adr));
      check("out_valid", {7'b0, out_valid}, {7'b0, mdl_q.size() != 0});
      check("done", {7'b0, done}, {7'b0, done_m});
      check("overflow", {7'b0, overflow}, {7'b0, ovf_m});
      check("addr_err", {7'b0, addr_err}, {7'b0, aerr_m});
      pop = rdy && (mdl_q.size() != 0);
      if (pop) void'(mdl_q.pop_front());
      if (we) begin
         if (adr < RAM_DEPTH) ram_m[adr] = wd;
         if (adr == 8'hFD && wd == 8'h01) done_m = 1'b1;
         if (adr == 8'hFF) begin
            if (mdl_q.size() < FIFO_DEPTH || pop) begin
               mdl_q.push_back(wd);
               exp_q.push_back(wd);
            end else begin
               ovf_m = 1'b1;
            end
         end
`ifdef DATA_MEM_ADDR_CHECK_EN
         if ((adr >= RAM_DEPTH && adr < 8'hFD) || adr == 8'hFE) aerr_m = 1'b1;
`endif
      end
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      memwrite  = 1'b0;
      out_ready = 1'b0;
      reset     = 1'b1;
      clear_model();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Monitor: every accepted pop must present the oldest expected entry.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected actual=%h expected=none at %0t", out_data, $time);
         end else begin
            check("out_data", out_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [7:0] a, d;
      int r;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      cycle(0, 8'h10, 8'h00, 0);
      cycle(0, 8'hFE, 8'h00, 0);
      // RAM store, read-during-write, then readback
      cycle(1, 8'h10, 8'h5A, 0);
      cycle(0, 8'h10, 8'h00, 0);
      // FIFO ordering
      cycle(1, 8'hFF, 8'h11, 0);
      cycle(1, 8'hFF, 8'h22, 0);
      cycle(1, 8'hFF, 8'h33, 0);
      cycle(0, 8'hFE, 8'h00, 0);
      repeat (3) cycle(0, 8'hFF, 8'h00, 1);
      cycle(0, 8'hFF, 8'h00, 0);
      // Overflow when full without pop
      for (int i = 0; i < 4; i++) cycle(1, 8'hFF, 8'hA0 + 8'(i), 0);
      cycle(1, 8'hFF, 8'hA4, 0);
      cycle(0, 8'hFE, 8'h00, 0);
      repeat (5) cycle(0, 8'hFF, 8'h00, 1);
      // Push while full with simultaneous pop
      reset_pulse();
      for (int i = 0; i < 4; i++) cycle(1, 8'hFF, 8'hA0 + 8'(i), 0);
      cycle(1, 8'hFF, 8'hB0, 1);
      cycle(0, 8'hFE, 8'h00, 0);
      repeat (5) cycle(0, 8'hFF, 8'h00, 1);
      // Done flag
      cycle(1, 8'hFD, 8'h02, 0);
      cycle(1, 8'hFD, 8'h01, 0);
      cycle(0, 8'hFE, 8'h00, 0);
      // Unmapped store must not alias into RAM
      cycle(1, 8'h00, 8'h3C, 0);
      cycle(1, 8'h80, 8'h77, 0);
      cycle(1, 8'hFE, 8'h55, 0);
      cycle(0, 8'h00, 8'h00, 0);
      cycle(0, 8'h80, 8'h00, 0);
      // Asynchronous reset mid-drain
      cycle(1, 8'hFF, 8'hC1, 0);
      cycle(1, 8'hFF, 8'hC2, 0);
      memwrite  = 1'b0;
      out_ready = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      check("async_out_valid", {7'b0, out_valid}, 8'h00);
      check("async_done", {7'b0, done}, 8'h00);
      check("async_out_data", out_data, 8'h00);
      clear_model();
      @(posedge clk);
      #1;
      reset = 1'b0;
      cycle(0, 8'h10, 8'h00, 0);
      cycle(0, 8'hFE, 8'h00, 0);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 6);
         d = 8'($urandom_range(0, 255));
         case (r)
            0, 1: a = 8'($urandom_range(0, RAM_DEPTH - 1));
            2: begin a = 8'hFD; if ($urandom_range(0, 1) == 0) d = 8'h01; end
            3: a = 8'hFE;
            4, 5: a = 8'hFF;
            default: a = 8'($urandom_range(RAM_DEPTH, 252));
         endcase
         cycle(bit'($urandom_range(0, 1)), a, d, $urandom_range(0, 9) < 4);
         if ($urandom_range(0, 99) == 0) reset_pulse();
      end

      repeat (FIFO_DEPTH + 2) cycle(0, 8'hFF, 8'h00, 1);
      check("scoreboard_empty", 8'(exp_q.size()), 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
